// File: rtl/sine_tbl_pkg.sv
// rtl/sine_tbl_pkg.sv - shared types and constants for the sine table loader
// Purpose: default widths, table depth, FSM state type and the full write mask.
// Ports: none (package).
package sine_tbl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH      = 256;

  // Wide enough for any sane DATA_W; users slice the low DATA_W/8 bits.
  localparam logic [127:0] WMASK_ALL = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_FLUSH,
    ST_VERIFY_RD,
    ST_VERIFY_CMP
  } state_e;

endpackage

// File: rtl/tbl_xor_accum.sv
// rtl/tbl_xor_accum.sv - XOR accumulator used for the readback checksum
// Purpose: sum_q ^= data on enable; clear has priority and zeroes the sum.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   clear           zero the running sum
//   enable          fold data into the sum
//   data [W-1:0]    word to fold in
//   sum  [W-1:0]    running XOR of all enabled words since the last clear
module tbl_xor_accum
  import sine_tbl_pkg::*;
#(
  parameter int W = DATA_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] data,
  output logic [W-1:0] sum
);

  logic [W-1:0] sum_q;
  logic [W-1:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (enable) begin
      sum_d = sum_q ^ data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/sine_table_loader.sv
// rtl/sine_table_loader.sv - loads the sine lookup SRAM through port 0 and gates the phase counter
// Purpose: accepts a valid/ready word stream and writes it to consecutive
// (mod 2**ADDR_W) SRAM addresses starting at base_addr; signals done and
// table_valid when the load completes, and holds run_en low otherwise.
// Optional build macro: SINE_TABLE_LOADER_READBACK_CHECK_EN adds an XOR
// checksum readback pass (mem_dout0 input, chk_err output).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, abort               load request (IDLE only), cancel in-progress load
//   base_addr, len_m1          first address and word count minus one, latched on start
//   s_valid, s_ready, s_data   incoming word stream
//   mem_csb0 .. mem_din0       SRAM port 0 (registered)
//   run_req, run_en            phase counter request and gated enable
//   busy, done, table_valid    status
//   mem_dout0, chk_err         readback data and checksum error (macro only)
module sine_table_loader
  import sine_tbl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   len_m1,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [DATA_W-1:0]   s_data,
  output logic                mem_csb0,
  output logic                mem_web0,
  output logic [DATA_W/8-1:0] mem_wmask0,
  output logic [ADDR_W-1:0]   mem_addr0,
  output logic [DATA_W-1:0]   mem_din0,
`ifdef SINE_TABLE_LOADER_READBACK_CHECK_EN
  input  logic [DATA_W-1:0]   mem_dout0,
  output logic                chk_err,
`endif
  input  logic                run_req,
  output logic                run_en,
  output logic                busy,
  output logic                done,
  output logic                table_valid
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                csb_q, csb_d;
  logic                web_q, web_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic                start_go;
  logic                beat;

`ifdef SINE_TABLE_LOADER_READBACK_CHECK_EN
  logic                chk_err_q, chk_err_d;
  logic                rd_vld_q, rd_vld_d;
  logic                rd_on_port;
  logic                rd_acc_en;
  logic [DATA_W-1:0]   wr_sum;
  logic [DATA_W-1:0]   rd_sum;

  // A read is on the port this cycle; its data is returned next cycle.
  assign rd_on_port = !csb_q && web_q;
  assign rd_acc_en  = rd_vld_q &&
                      (state_q == ST_VERIFY_RD || state_q == ST_VERIFY_CMP);

  tbl_xor_accum #(.W(DATA_W)) u_wr_accum (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_go),
    .enable (beat),
    .data   (s_data),
    .sum    (wr_sum)
  );

  tbl_xor_accum #(.W(DATA_W)) u_rd_accum (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_go),
    .enable (rd_acc_en),
    .data   (mem_dout0),
    .sum    (rd_sum)
  );
`endif

  assign start_go = (state_q == ST_IDLE) && start;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    csb_d   = 1'b1;
    web_d   = 1'b1;
    wmask_d = '0;
    addr_d  = addr_q;
    din_d   = din_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    s_ready = 1'b0;
    beat    = 1'b0;
`ifdef SINE_TABLE_LOADER_READBACK_CHECK_EN
    chk_err_d = chk_err_q;
    rd_vld_d  = rd_on_port;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          len_d   = len_m1;
          cnt_d   = '0;
          valid_d = 1'b0;
          state_d = ST_WRITE;
`ifdef SINE_TABLE_LOADER_READBACK_CHECK_EN
          chk_err_d = 1'b0;
`endif
        end
      end

      ST_WRITE: begin
        // abort wins over a same-cycle beat, so ready is withdrawn with it.
        s_ready = !abort;
        if (abort) begin
          state_d = ST_IDLE;
        end else if (s_valid) begin
          beat    = 1'b1;
          csb_d   = 1'b0;
          web_d   = 1'b0;
          wmask_d = WMASK_ALL[DATA_W/8-1:0];
          addr_d  = base_q + cnt_q;
          din_d   = s_data;
          cnt_d   = cnt_q + ADDR_W'(1);
          if (cnt_q == len_q) begin
            state_d = ST_FLUSH;
          end
        end
      end

      ST_FLUSH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
`ifdef SINE_TABLE_LOADER_READBACK_CHECK_EN
          cnt_d   = '0;
          state_d = ST_VERIFY_RD;
`else
          done_d  = 1'b1;
          valid_d = 1'b1;
          state_d = ST_IDLE;
`endif
        end
      end

`ifdef SINE_TABLE_LOADER_READBACK_CHECK_EN
      ST_VERIFY_RD: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          csb_d  = 1'b0;
          addr_d = base_q + cnt_q;
          cnt_d  = cnt_q + ADDR_W'(1);
          if (cnt_q == len_q) begin
            state_d = ST_VERIFY_CMP;
          end
        end
      end

      ST_VERIFY_CMP: begin
        // Wait until the last read has left the port and been folded in.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!rd_on_port && !rd_vld_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
          if (rd_sum == wr_sum) begin
            valid_d = 1'b1;
          end else begin
            chk_err_d = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      csb_q   <= 1'b1;
      web_q   <= 1'b1;
      wmask_q <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      csb_q   <= csb_d;
      web_q   <= web_d;
      wmask_q <= wmask_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

`ifdef SINE_TABLE_LOADER_READBACK_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_err_q <= 1'b0;
      rd_vld_q  <= 1'b0;
    end else begin
      chk_err_q <= chk_err_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign chk_err = chk_err_q;
`endif

  assign mem_csb0   = csb_q;
  assign mem_web0   = web_q;
  assign mem_wmask0 = wmask_q;
  assign mem_addr0  = addr_q;
  assign mem_din0   = din_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  // Masking with start_go lets the phase counter freeze in the start cycle itself.
  assign table_valid = valid_q && !start_go;
  assign run_en      = run_req && table_valid;

endmodule

// File: tb/tb_sine_table_loader.sv
// tb/tb_sine_table_loader.sv - randomized scoreboard bench for sine_table_loader
module tb_sine_table_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  base_addr;
  logic [7:0]  len_m1;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        mem_csb0;
  logic        mem_web0;
  logic [3:0]  mem_wmask0;
  logic [7:0]  mem_addr0;
  logic [31:0] mem_din0;
  logic        run_req;
  logic        run_en;
  logic        busy;
  logic        done;
  logic        table_valid;

  int tests_run = 0;
  int tests_failed = 0;
  logic tv_model = 1'b0;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  sine_table_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .base_addr   (base_addr),
    .len_m1      (len_m1),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .mem_csb0    (mem_csb0),
    .mem_web0    (mem_web0),
    .mem_wmask0  (mem_wmask0),
    .mem_addr0   (mem_addr0),
    .mem_din0    (mem_din0),
    .run_req     (run_req),
    .run_en      (run_en),
    .busy        (busy),
    .done        (done),
    .table_valid (table_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every write seen on port 0 must be the next expected one.
  always @(negedge clk) begin
    if (!reset && !mem_csb0) begin
      wr_t e;
      check("write_web", {63'd0, mem_web0}, 64'd0);
      check("write_wmask", {60'd0, mem_wmask0}, 64'hF);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", {56'd0, mem_addr0}, 64'hFFFF);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", {56'd0, mem_addr0}, {56'd0, e.addr});
        check("write_data", {32'd0, mem_din0}, {32'd0, e.data});
      end
    end
  end

  // vmode: 0 valid always, 1 alternate cycles, 2 random.
  // abort_at / reset_at: beat index at which to abort / reset, -1 for none.
  task automatic load(input logic [7:0] base, input logic [7:0] len, input int vmode,
                      input bit data3, input int abort_at, input int reset_at);
    int n;
    int ticks;
    int guard;
    logic v;
    logic [7:0] a;
    logic [31:0] d;
    n = 0;
    guard = 0;
    start = 1'b1;
    base_addr = base;
    len_m1 = len;
    #1;
    check("run_en_start_cycle", {63'd0, run_en}, 64'd0);
    check("tv_start_cycle", {63'd0, table_valid}, 64'd0);
    tv_model = 1'b0;
    tick();
    start = 1'b0;
    ticks = 1;
    while (n <= int'(len) && guard < 2000) begin
      guard++;
      case (vmode)
        0: v = 1'b1;
        1: v = (guard % 2 == 1);
        default: v = ($urandom_range(1) == 1);
      endcase
      a = base + n[7:0];
      d = data3 ? 32'(a) * 32'd3 : $urandom;
      if (reset_at == n) begin
        reset = 1'b1;
        #1;
        check("rst_csb", {63'd0, mem_csb0}, 64'd1);
        check("rst_web", {63'd0, mem_web0}, 64'd1);
        check("rst_wmask", {60'd0, mem_wmask0}, 64'd0);
        check("rst_addr", {56'd0, mem_addr0}, 64'd0);
        check("rst_din", {32'd0, mem_din0}, 64'd0);
        check("rst_s_ready", {63'd0, s_ready}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_tv", {63'd0, table_valid}, 64'd0);
        exp_q.delete();
        s_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        return;
      end
      if (abort_at == n && v) begin
        s_valid = 1'b1;
        s_data = d;
        abort = 1'b1;
        #1;
        check("s_ready_abort", {63'd0, s_ready}, 64'd0);
        tick();
        abort = 1'b0;
        s_valid = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_tv", {63'd0, table_valid}, 64'd0);
        check("abort_run_en", {63'd0, run_en}, 64'd0);
        tick();
        check("abort_no_done", {63'd0, done}, 64'd0);
        check("abort_writes_drained", 64'(exp_q.size()), 64'd0);
        return;
      end
      s_valid = v;
      s_data = d;
      #1;
      check("s_ready_write", {63'd0, s_ready}, 64'd1);
      if (v) begin
        exp_q.push_back('{addr: a, data: d});
        n++;
      end
      tick();
      ticks++;
    end
    s_valid = 1'b0;
    if (guard >= 2000) check("load_budget", 64'(guard), 64'd0);
    check("flush_s_ready", {63'd0, s_ready}, 64'd0);
    check("flush_busy", {63'd0, busy}, 64'd1);
    check("flush_done", {63'd0, done}, 64'd0);
    tick();
    ticks++;
    tv_model = 1'b1;
    check("done_pulse", {63'd0, done}, 64'd1);
    check("done_tv", {63'd0, table_valid}, 64'd1);
    check("done_busy", {63'd0, busy}, 64'd0);
    if (vmode == 0) check("done_latency", 64'(ticks), 64'(int'(len) + 3));
    tick();
    check("done_one_cycle", {63'd0, done}, 64'd0);
    check("writes_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_run_en();
    for (int k = 0; k < 3; k++) begin
      run_req = ($urandom_range(1) == 1);
      #1;
      check("run_en", {63'd0, run_en}, {63'd0, run_req & tv_model});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    base_addr = '0;
    len_m1 = '0;
    s_valid = 1'b0;
    s_data = '0;
    run_req = 1'b1;
    tick();
    tick();
    check("reset_csb", {63'd0, mem_csb0}, 64'd1);
    check("reset_s_ready", {63'd0, s_ready}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_tv", {63'd0, table_valid}, 64'd0);
    check("reset_run_en", {63'd0, run_en}, 64'd0);
    reset = 1'b0;
    tick();

    // Full table, data = addr*3, valid held high.
    load(8'h00, 8'hFF, 0, 1'b1, -1, -1);
    run_req = 1'b1;
    #1;
    check("run_en_after_full", {63'd0, run_en}, 64'd1);
    check_run_en();

    // Wrap with backpressure.
    load(8'hF8, 8'h0F, 1, 1'b0, -1, -1);
    check_run_en();

    // Single-word and random loads.
    load(8'hFF, 8'h00, 0, 1'b0, -1, -1);
    for (int i = 0; i < 5; i++) begin
      load(8'($urandom), 8'($urandom_range(40)), 2, 1'b0, -1, -1);
      check_run_en();
    end

    // Abort on the 6th beat.
    run_req = 1'b1;
    load(8'h10, 8'h1F, 0, 1'b0, 5, -1);
    tv_model = 1'b0;
    check_run_en();

    // Reset mid-load then a clean load.
    load(8'h20, 8'h1F, 0, 1'b0, -1, 10);
    tv_model = 1'b0;
    check_run_en();
    load(8'h20, 8'h1F, 2, 1'b0, -1, -1);

    // Reload while running: run_en drops in start cycle, returns after done.
    run_req = 1'b1;
    #1;
    check("reload_run_en_before", {63'd0, run_en}, 64'd1);
    load(8'h80, 8'h07, 0, 1'b0, -1, -1);
    check("reload_run_en_after", {63'd0, run_en}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
